// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage types: run-state encoding and default address/instruction widths
// used by fetch, ROM and decode.
package inst_fetch_pkg;

   localparam int FETCH_A = 12;
   localparam int FETCH_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/prog_ctr.sv
// Program counter: load START_ADDR, load branch target (absolute or InstPC-relative), increment or hold.
// Single register, 1-cycle update; holds whenever no load/increment is requested.
module prog_ctr
   import inst_fetch_pkg::*;
#(
   parameter int             A          = FETCH_A,
   parameter logic [A-1:0]   START_ADDR = '0
)
(
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load_start,
   input  logic         i_load_branch,
   input  logic         i_inc,
   input  logic         i_branch_rel,
   input  logic [A-1:0] i_branch_target,
   input  logic [A-1:0] i_base_pc,
   output logic [A-1:0] o_pc
);

   logic [A-1:0] r_pc;
   logic [A-1:0] w_target;
   logic [A-1:0] w_pc_nxt;

   // Relative offsets are A-bit two's complement, so a plain truncated add handles negatives.
   assign w_target = i_branch_rel ? (i_base_pc + i_branch_target) : i_branch_target;

   always_comb begin
      w_pc_nxt = r_pc;
      if (i_load_start)
         w_pc_nxt = START_ADDR;
      else if (i_load_branch)
         w_pc_nxt = w_target;
      else if (i_inc)
         w_pc_nxt = r_pc + A'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_pc <= START_ADDR;
      else
         r_pc <= w_pc_nxt;
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns PC, drives ROM address, registers ROM word; latency 1 cycle, 1-cycle branch bubble.
// Stall freezes PC and fetch register; Halt ends the run until the next Start.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int             A          = FETCH_A,
   parameter int             W          = FETCH_W,
   parameter logic [A-1:0]   START_ADDR = '0
)
(
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         Start,
   input  logic         Stall,
   input  logic         Halt,
   input  logic         BranchEn,
   input  logic         BranchRel,
   input  logic [A-1:0] BranchTarget,
   input  logic [W-1:0] InstIn,
   output logic [A-1:0] InstAddress,
   output logic [W-1:0] Inst,
   output logic [A-1:0] InstPC,
   output logic         InstValid,
   output logic         Done
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;

   logic         w_load_start;
   logic         w_load_branch;
   logic         w_fetch;
   logic         w_clr_valid;
   logic [A-1:0] w_pc;

   logic [W-1:0] r_inst;
   logic [A-1:0] r_inst_pc;
   logic         r_inst_valid;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Halt outranks BranchEn so a halting instruction is never redirected; BranchEn outranks Stall.
   always_comb begin
      w_state_nxt   = r_state;
      w_load_start  = 1'b0;
      w_load_branch = 1'b0;
      w_fetch       = 1'b0;
      w_clr_valid   = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (Start) begin
               w_state_nxt  = ST_RUN;
               w_load_start = 1'b1;
            end
         end
         ST_RUN: begin
            if (Halt) begin
               w_state_nxt = ST_DONE;
               w_clr_valid = 1'b1;
            end else if (BranchEn) begin
               w_load_branch = 1'b1;
               w_clr_valid   = 1'b1;
            end else if (!Stall) begin
               w_fetch = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   prog_ctr #(
      .A          (A),
      .START_ADDR (START_ADDR)
   ) u_prog_ctr (
      .i_clk           (Clk),
      .i_rst_n         (Reset_n),
      .i_load_start    (w_load_start),
      .i_load_branch   (w_load_branch),
      .i_inc           (w_fetch),
      .i_branch_rel    (BranchRel),
      .i_branch_target (BranchTarget),
      .i_base_pc       (r_inst_pc),
      .o_pc            (w_pc)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_inst       <= '0;
         r_inst_pc    <= '0;
         r_inst_valid <= 1'b0;
      end else if (w_fetch) begin
         r_inst       <= InstIn;
         r_inst_pc    <= w_pc;
         r_inst_valid <= 1'b1;
      end else if (w_clr_valid) begin
         r_inst_valid <= 1'b0;
      end
   end

   assign InstAddress = w_pc;
   assign Inst        = r_inst;
   assign InstPC      = r_inst_pc;
   assign InstValid   = r_inst_valid;
   assign Done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized control inputs, all checked
// against a cycle-level behavioural model with a random-content ROM.
module tb_inst_fetch;

   localparam int          A     = 12;
   localparam int          W     = 10;
   localparam logic [11:0] START = 12'h000;

   logic         Clk;
   logic         Reset_n;
   logic         Start, Stall, Halt, BranchEn, BranchRel;
   logic [11:0]  BranchTarget;
   logic [9:0]   InstIn;
   logic [11:0]  InstAddress;
   logic [9:0]   Inst;
   logic [11:0]  InstPC;
   logic         InstValid;
   logic         Done;

   logic [9:0]   rom [0:4095];

   int n_tests = 0;
   int n_fail  = 0;

   // Model: run mode 0=idle, 1=running, 2=finished.
   int           m_mode;
   logic [11:0]  m_pc;
   logic [9:0]   m_inst;
   logic [11:0]  m_instpc;
   logic         m_valid;
   logic [11:0]  saved_pc;

   inst_fetch #(.A(A), .W(W), .START_ADDR(START)) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Start        (Start),
      .Stall        (Stall),
      .Halt         (Halt),
      .BranchEn     (BranchEn),
      .BranchRel    (BranchRel),
      .BranchTarget (BranchTarget),
      .InstIn       (InstIn),
      .InstAddress  (InstAddress),
      .Inst         (Inst),
      .InstPC       (InstPC),
      .InstValid    (InstValid),
      .Done         (Done)
   );

   assign InstIn = rom[InstAddress];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode   = 0;
      m_pc     = START;
      m_inst   = '0;
      m_instpc = '0;
      m_valid  = 1'b0;
   endtask

   task automatic compare_all(input string tag);
      chk({tag, ".addr"},  32'(InstAddress), 32'(m_pc));
      chk({tag, ".inst"},  32'(Inst),        32'(m_inst));
      chk({tag, ".ipc"},   32'(InstPC),      32'(m_instpc));
      chk({tag, ".valid"}, 32'(InstValid),   32'(m_valid));
      chk({tag, ".done"},  32'(Done),        32'(m_mode == 2));
   endtask

   // Drive inputs just after a falling edge, advance the model over the next rising edge,
   // then compare on the following falling edge.
   task automatic step(input string tag, input logic st, input logic sl, input logic hl,
                       input logic be, input logic br, input logic [11:0] bt);
      Start = st; Stall = sl; Halt = hl; BranchEn = be; BranchRel = br; BranchTarget = bt;
      if (m_mode == 1) begin
         if (hl) begin
            m_mode  = 2;
            m_valid = 1'b0;
         end else if (be) begin
            m_pc    = br ? m_instpc + bt : bt;
            m_valid = 1'b0;
         end else if (!sl) begin
            m_inst   = rom[m_pc];
            m_instpc = m_pc;
            m_valid  = 1'b1;
            m_pc     = m_pc + 12'd1;
         end
      end else if (st) begin
         m_mode = 1;
         m_pc   = START;
      end
      @(posedge Clk);
      @(negedge Clk);
      compare_all(tag);
   endtask

   task automatic run(input string tag);
      step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) rom[i] = 10'($urandom);
      Reset_n = 1'b0;
      Start = 1'b0; Stall = 1'b0; Halt = 1'b0; BranchEn = 1'b0; BranchRel = 1'b0;
      BranchTarget = '0;
      model_reset();
      repeat (2) @(negedge Clk);
      compare_all("reset");
      Reset_n = 1'b1;
      run("idle");

      // Start, then sequential fetch of words 0..3.
      step("start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
      chk("first_addr", 32'(InstAddress), 32'(START));
      chk("first_valid", 32'(InstValid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         run("seq");
         chk("seq_addr", 32'(InstAddress), 32'(i + 1));
         chk("seq_ipc", 32'(InstPC), 32'(i));
         chk("seq_inst", 32'(Inst), 32'(rom[i]));
         chk("seq_valid", 32'(InstValid), 32'd1);
      end
      run("to5");

      // Stall three cycles at PC=5.
      for (int i = 0; i < 3; i++) begin
         step("stall", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
         chk("stall_addr", 32'(InstAddress), 32'd5);
         chk("stall_ipc", 32'(InstPC), 32'd4);
      end
      run("unstall");
      chk("unstall_addr", 32'(InstAddress), 32'd6);

      // Relative branch back by 4 from InstPC=10, then absolute to 0x200.
      for (int i = 0; i < 20 && !(InstPC == 12'd10 && InstValid); i++) run("to10");
      chk("at_ipc10", 32'(InstPC), 32'd10);
      step("brrel", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'hFFC);
      chk("brrel_addr", 32'(InstAddress), 32'd6);
      chk("brrel_bubble", 32'(InstValid), 32'd0);
      run("brrel_tgt");
      chk("brrel_tgt_ipc", 32'(InstPC), 32'd6);
      chk("brrel_tgt_valid", 32'(InstValid), 32'd1);
      step("brabs", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h200);
      chk("brabs_addr", 32'(InstAddress), 32'h200);

      // PC wrap and relative wrap.
      step("to_fff", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'hFFF);
      run("wrap");
      chk("wrap_addr", 32'(InstAddress), 32'd0);
      chk("wrap_ipc", 32'(InstPC), 32'hFFF);
      step("to_ffe", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'hFFE);
      run("fetch_ffe");
      step("brrel_wrap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h004);
      chk("brrel_wrap_addr", 32'(InstAddress), 32'd2);

      // Halt together with BranchEn: halt wins, PC not redirected.
      run("pre_halt");
      saved_pc = InstAddress;
      step("halt", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h123);
      chk("halt_done", 32'(Done), 32'd1);
      chk("halt_addr", 32'(InstAddress), 32'(saved_pc));
      step("done_ign", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h456);
      chk("done_ign_addr", 32'(InstAddress), 32'(saved_pc));
      chk("done_hold", 32'(Done), 32'd1);
      step("restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
      chk("restart_addr", 32'(InstAddress), 32'(START));
      chk("restart_done", 32'(Done), 32'd0);

      // Randomized control traffic.
      for (int i = 0; i < 500; i++) begin
         step("rand",
              1'($urandom_range(99) < 8),
              1'($urandom_range(99) < 20),
              1'($urandom_range(99) < 3),
              1'($urandom_range(99) < 10),
              1'($urandom_range(1)),
              12'($urandom));
      end

      // Asynchronous reset between edges while running.
      step("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
      for (int i = 0; i < 3; i++) run("pre_rst_run");
      #2;
      Reset_n = 1'b0;
      #1;
      model_reset();
      chk("arst_valid", 32'(InstValid), 32'd0);
      chk("arst_done", 32'(Done), 32'd0);
      chk("arst_inst", 32'(Inst), 32'd0);
      chk("arst_addr", 32'(InstAddress), 32'(START));
      Start = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      compare_all("rst_start_ign");
      Reset_n = 1'b1;
      run("post_rst_idle");
      step("post_rst_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
      run("post_rst_fetch");
      chk("post_rst_ipc", 32'(InstPC), 32'(START));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage that sits directly upstream of the instruction ROM. It owns the program counter, drives the ROM address, and captures the combinational ROM word into a fetched-instruction register for decode. It also runs the program start/done handshake and applies branch redirects from execute, flushing the wrong-path fetch.

## Interface
- A, 12, PC / ROM address width
- W, 10, instruction width
- START_ADDR, 0, PC value loaded on reset and on every Start
- Clk  in  1  system clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  level/pulse; begins a program run from IDLE or DONE
- Stall  in  1  downstream hazard; freezes PC and fetch register
- Halt  in  1  decode/execute reached the halt instruction
- BranchEn  in  1  redirect request for the instruction held in Inst/InstPC
- BranchRel  in  1  1: target is PC-relative offset; 0: absolute
- BranchTarget  in  A  absolute address, or two's-complement offset
- InstIn  in  W  ROM data for InstAddress (combinational ROM)
- InstAddress  out  A  ROM address (equals PC)
- Inst  out  W  fetched instruction register
- InstPC  out  A  address Inst was fetched from
- InstValid  out  1  Inst holds a valid right-path instruction
- Done  out  1  program finished; held until next Start

## Operation
- States: IDLE, RUN, DONE. Reset (Reset_n=0, async): state=IDLE, PC=START_ADDR, Inst=0, InstPC=0, InstValid=0, Done=0.
- IDLE: PC held at START_ADDR, InstValid=0. Start=1 -> RUN.
- RUN, per edge, priority highest first:
  - Halt=1 -> DONE, InstValid<=0, Done<=1; PC unchanged.
  - BranchEn=1 (overrides Stall) -> PC <= BranchRel ? InstPC + BranchTarget (mod 2^A) : BranchTarget; InstValid<=0 (flush).
  - Stall=1 -> PC, Inst, InstPC, InstValid hold.
  - else -> Inst<=InstIn, InstPC<=PC, InstValid<=1, PC<=PC+1 (mod 2^A).
- DONE: InstValid=0, Done=1, PC frozen. Start=1 -> RUN, PC<=START_ADDR, Done<=0.
- Start in RUN ignored. Halt/BranchEn/Stall ignored outside RUN.
- Arithmetic: all PC sums truncated to A bits; PC=2^A-1 increments to 0; relative offset is A-bit two's complement, no extension needed.

## Timing
- InstAddress = PC register, no combinational path from any input.
- Fetch latency 1: address presented in cycle n, Inst/InstValid reflect it after edge n.
- First fetch: Start sampled at edge k; InstAddress=START_ADDR during cycle k+1; InstValid=1 after edge k+1.
- Branch penalty 1 cycle: after BranchEn edge, InstValid=0 for one cycle, target instruction valid after the next edge.
- Done asserts the cycle after Halt is sampled and stays high until Start is sampled in DONE.
- Reset mid-run: all outputs return to reset values immediately (asynchronous), no partial PC update.

## Structure
- Shared package: fetch_state_t enum (IDLE, RUN, DONE) and default A/W widths used by fetch, ROM and decode.
- One sub-module: prog_ctr (PC register with load/increment/hold and relative adder); FSM and fetch register stay in inst_fetch.

## Test plan
- Reset then Start pulse, ROM words 0..3 -> InstAddress 0,1,2,3 on successive cycles; Inst/InstPC lag one cycle; InstValid=1 from 2nd cycle after Start.
- Stall high 3 cycles at PC=5 -> InstAddress stays 5, Inst/InstPC/InstValid unchanged; resumes with PC=6 on release.
- BranchEn with InstPC=10, BranchRel=1, BranchTarget=12'hFFC (-4) -> next InstAddress=6, InstValid=0 one cycle; absolute BranchTarget=0x200 -> InstAddress=0x200.
- Halt and BranchEn together in same cycle -> DONE, Done=1, PC not redirected; new Start -> InstAddress=START_ADDR, Done=0.
- PC=12'hFFF unstalled -> next InstAddress=0; relative branch InstPC=12'hFFE, offset 4 -> InstAddress=2.
- Reset_n low mid-run asynchronously (between edges) -> InstValid, Done, Inst immediately 0, InstAddress=START_ADDR; Start ignored while Reset_n=0.
